// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer. Owns the PC, reads the word-indexed
// instruction ROM combinationally, and pushes {pc, instr} into a 2-entry FIFO
// consumed by decode over a valid/ready handshake. Redirects flush the FIFO;
// a HALT_WORD fetch parks the sequencer until the next redirect.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
   input  logic        clock,
   input  logic        reset,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic        halted,
   output logic [31:0] fetch_count
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [1:0]  count_q, count_d;
   logic [31:0] fetch_count_q, fetch_count_d;
   // Slot 0 is always the FIFO head; slot 1 is the entry behind it.
   logic [31:0] e0_pc_q, e0_pc_d, e0_instr_q, e0_instr_d;
   logic [31:0] e1_pc_q, e1_pc_d, e1_instr_q, e1_instr_d;

   logic        pop;
   logic        push;
   logic [1:0]  wr_slot;
   logic        unused_redirect_bits;

   // Redirect targets are word aligned, so the low two bits are ignored.
   assign unused_redirect_bits = ^redirect_pc[1:0];

   assign imem_addr   = {24'b0, pc_q[9:2]};
   assign out_valid   = (count_q != 2'd0);
   assign out_pc      = e0_pc_q;
   assign out_instr   = e0_instr_q;
   assign halted      = (state_q == HALTED);
   assign fetch_count = fetch_count_q;

   // Next-state: FSM, PC, FIFO shift/fill and fetch counter.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      count_d       = count_q;
      fetch_count_d = fetch_count_q;
      e0_pc_d       = e0_pc_q;
      e0_instr_d    = e0_instr_q;
      e1_pc_d       = e1_pc_q;
      e1_instr_d    = e1_instr_q;
      wr_slot       = 2'd0;

      pop  = out_valid & out_ready;
      // A redirect suppresses the push; a full FIFO only accepts when draining.
      push = (state_q == RUN) && !redirect_valid &&
             ((count_q < 2'd2) || pop);

      if (redirect_valid) begin
         // Flush wins over everything; a same-cycle pop simply completes.
         count_d = 2'd0;
         pc_d    = {redirect_pc[31:2], 2'b00};
         state_d = RUN;
      end else begin
         case (state_q)
            IDLE:    state_d = RUN;
            RUN:     if (push && (imem_data == HALT_WORD)) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
         endcase

         if (pop) begin
            e0_pc_d    = e1_pc_q;
            e0_instr_d = e1_instr_q;
         end

         if (push) begin
            // Write position accounts for the head leaving this same edge.
            wr_slot = count_q - {1'b0, pop};
            if (wr_slot == 2'd0) begin
               e0_pc_d    = pc_q;
               e0_instr_d = imem_data;
            end else begin
               e1_pc_d    = pc_q;
               e1_instr_d = imem_data;
            end
            pc_d          = pc_q + 32'd4;
            fetch_count_d = fetch_count_q + 32'd1;
         end

         count_d = count_q - {1'b0, pop} + {1'b0, push};
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         pc_q          <= {RESET_PC[31:2], 2'b00};
         count_q       <= 2'd0;
         fetch_count_q <= 32'd0;
         e0_pc_q       <= 32'd0;
         e0_instr_q    <= 32'd0;
         e1_pc_q       <= 32'd0;
         e1_instr_q    <= 32'd0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         count_q       <= count_d;
         fetch_count_q <= fetch_count_d;
         e0_pc_q       <= e0_pc_d;
         e0_instr_q    <= e0_instr_d;
         e1_pc_q       <= e1_pc_d;
         e1_instr_q    <= e1_instr_d;
      end
   end

endmodule
